// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous BRAM port between CPU fetch and a
// loader/debug port, with a bounded loader burst so fetch is never starved.
module imem_arbiter #(
  parameter int unsigned LD_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_err,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_LOAD} rd_state_e;

  localparam logic [3:0] BurstMax = 4'(LD_BURST);

  rd_state_e  rd_state_q, rd_state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       ld_aligned;

  // Byte-offset bits of the fetch address carry no information for a word RAM.
  logic       unused_fetch_lsb;
  assign unused_fetch_lsb = ^fetch_addr[1:0];

  assign ld_aligned  = ld_req && (ld_addr[1:0] == 2'b00);
  assign ld_err      = ld_req && (ld_addr[1:0] != 2'b00);
  assign ld_gnt      = !rst && ld_aligned && (!fetch_req || (burst_cnt_q < BurstMax));
  assign fetch_gnt   = !rst && fetch_req && !ld_gnt;
  assign fetch_stall = fetch_req && !fetch_gnt;

  always_comb begin
    ram_en    = fetch_gnt || ld_gnt;
    ram_we    = ld_gnt && ld_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ld_gnt) begin
      ram_addr  = ld_addr[31:2];
      ram_wdata = ld_wdata;
    end else if (fetch_gnt) begin
      ram_addr  = fetch_addr[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
      rd_state_q  <= R_IDLE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_state_q  <= rd_state_d;
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (ld_gnt) begin
      if (burst_cnt_q < BurstMax) burst_cnt_d = burst_cnt_q + 4'd1;
    end else if (fetch_gnt) begin
      burst_cnt_d = '0;
    end
  end

  // rd_state records who owned the RAM read last cycle; writes produce no response.
  always_comb begin
    rd_state_d = R_IDLE;
    if (fetch_gnt)            rd_state_d = R_FETCH;
    else if (ld_gnt && !ld_we) rd_state_d = R_LOAD;
  end

  // Responses are masked during reset so an in-flight read is dropped immediately.
  always_comb begin
    fetch_valid = 1'b0;
    fetch_rdata = '0;
    ld_rvalid   = 1'b0;
    ld_rdata    = '0;
    if (!rst) begin
      unique case (rd_state_q)
        R_FETCH: begin
          fetch_valid = 1'b1;
          fetch_rdata = ram_rdata;
        end
        R_LOAD: begin
          ld_rvalid = 1'b1;
          ld_rdata  = ram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 The block SHALL have parameter LD_BURST, default 4, giving the maximum consecutive loader grants while fetch is waiting (legal range 1..15).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  CPU fetch request
- fetch_addr  in  32  CPU byte address
- fetch_gnt  out  1  fetch owns the RAM this cycle
- fetch_stall  out  1  drive low on IF/ID enable
- fetch_valid  out  1  fetch data valid
- fetch_rdata  out  32  fetch instruction word
- ld_req  in  1  loader/debug request
- ld_we  in  1  loader write (1) or read (0)
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader access accepted this cycle
- ld_err  out  1  misaligned loader access rejected
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  32  loader read data
- ram_en  out  1  BRAM enable
- ram_we  out  1  BRAM write enable
- ram_addr  out  30  BRAM word address
- ram_wdata  out  32  BRAM write data
- ram_rdata  in  32  BRAM synchronous read data, valid one cycle after access

Function
REQ-004 The block SHALL arbitrate every cycle from registered state only; all grant outputs are combinational from current inputs and registered state.
REQ-005 The block SHALL define an aligned loader request as ld_req=1 and ld_addr[1:0]=00.
REQ-006 The block SHALL grant the loader when there is an aligned loader request and either fetch_req=0 or burst_cnt<LD_BURST.
REQ-007 The block SHALL otherwise grant fetch when fetch_req=1; otherwise no access occurs (ram_en=0).
REQ-008 The block SHALL never assert fetch_gnt and ld_gnt in the same cycle.
REQ-009 The block SHALL assert ld_err for the same cycle, with ld_gnt=0 and no RAM access, when there is a misaligned ld_req (ld_addr[1:0]!=00); fetch arbitration then proceeds as if ld_req=0.
REQ-010 On a fetch grant, the block SHALL drive ram_en=1, ram_we=0, and ram_addr=fetch_addr[31:2].
REQ-011 On a loader grant, the block SHALL drive ram_en=1, ram_we=ld_we, ram_addr=ld_addr[31:2], and ram_wdata=ld_wdata.
REQ-012 With no grant, the block SHALL drive ram_we=0.
REQ-013 The block SHALL assert fetch_stall as fetch_req AND NOT fetch_gnt.
REQ-014 The block SHALL maintain burst_cnt (4-bit) as follows:
- increment, saturating at LD_BURST, on each loader grant;
- clear to 0 on each fetch grant;
- otherwise hold.
REQ-015 The block SHALL implement FSM rd_state with states R_IDLE, R_FETCH, R_LOAD, recording the read owner of the previous cycle.
- Next state is R_FETCH on a fetch grant.
- Next state is R_LOAD on a loader read grant (ld_we=0).
- Next state is R_IDLE otherwise, including loader writes.
REQ-016 In R_FETCH, the block SHALL drive fetch_valid=1 and fetch_rdata=ram_rdata.
REQ-017 In R_LOAD, the block SHALL drive ld_rvalid=1 and ld_rdata=ram_rdata.
REQ-018 fetch_rdata and ld_rdata SHALL be 0 whenever their valid is 0.
REQ-019 Read latency SHALL be exactly 1 cycle from grant to valid for both requesters; writes produce no response.
REQ-020 When loader and fetch are both continuously requesting, the grant pattern SHALL be LD_BURST loader grants then 1 fetch grant, repeating; fetch is never starved.
REQ-021 The block SHALL treat a loader write to the address fetch reads in the next cycle as ordinary; the fetch returns the written data (BRAM write-first is a RAM property, not guaranteed here).

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL clear burst_cnt to 0 and set rd_state to R_IDLE.
REQ-023 While rst=1, the block SHALL force all grant outputs, ram_en, and ram_we to 0; fetch_stall SHALL equal fetch_req.
REQ-024 Reset mid-operation SHALL drop any pending read response; fetch_valid and ld_rvalid SHALL be 0 in the cycle after reset is sampled.
REQ-025 In the first cycle after rst deasserts, arbitration SHALL resume from burst_cnt=0.

Verification
REQ-026 Fetch only: fetch_req=1, fetch_addr=0x0000_0010 -> ram_addr=0x4, fetch_gnt=1, fetch_stall=0; next cycle fetch_valid=1, fetch_rdata=RAM[4].
REQ-027 Contention with LD_BURST=4: fetch_req=1 and ld_req=1 held for 10 cycles -> grants L,L,L,L,F,L,L,L,L,F; fetch_stall=1 on the 8 loader cycles.
REQ-028 Loader write then read: write 0xDEADBEEF at 0x20, then read 0x20 -> ld_gnt=1 both cycles; ld_rvalid=1 only after the read, ld_rdata=0xDEADBEEF.
REQ-029 Misaligned: ld_req=1, ld_addr=0x22, fetch_req=1 -> ld_err=1, ld_gnt=0, fetch_gnt=1, ram_addr=fetch_addr[31:2].
REQ-030 Reset mid-read: loader read granted in cycle n, rst=1 in cycle n+1 -> ld_rvalid=0 in cycle n+1 and n+2, burst_cnt=0, no ram_en during reset.
